fir_tap_mac: RTL and testbench

- Downstream consumer of the 8-bank coefficient memory (cmem: 8 banks x 64 words x 16 bit, 8 independent 6-bit read addresses, active-low CEN/WEN).
- On each `start`, sweeps tap index k = 0..TAPS-1, driving the same k to all 8 cmem read addresses and to the sample memory address `XA`.
- Multiplies the 8 coefficient/sample pairs each cycle, sums them through a registered adder tree, and accumulates over all taps.
- Presents one filter output `y` with a single-cycle `y_valid` pulse.

---
 rtl/fir_tap_mac.sv | 208 ++++++++++++++++++++
 tb/tb_fir_tap_mac.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/fir_tap_mac.sv
// rtl/fir_tap_mac.sv - 8-lane coefficient x sample MAC sweeping TAPS addresses per output
//
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   start, busy       : begin one output computation / computation in progress
//   A7..A0, CEN, WEN  : coefficient memory read addresses, active-low enables
//   XA                : sample memory read address (same as A0)
//   Q7..Q0, X7..X0    : coefficient and sample read data, signed, READ_LAT after address
//   y, y_valid        : accumulated result and its one-cycle update pulse

module fir_tap_mac #(
   parameter int TAPS     = 64,
   parameter int AW       = 6,
   parameter int DW       = 16,
   parameter int READ_LAT = 1,
   parameter int ACC_W    = 41
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   output logic                    busy,
   output logic [AW-1:0]           A7,
   output logic [AW-1:0]           A6,
   output logic [AW-1:0]           A5,
   output logic [AW-1:0]           A4,
   output logic [AW-1:0]           A3,
   output logic [AW-1:0]           A2,
   output logic [AW-1:0]           A1,
   output logic [AW-1:0]           A0,
   output logic                    CEN,
   output logic                    WEN,
   output logic [AW-1:0]           XA,
   input  logic signed [DW-1:0]    Q7,
   input  logic signed [DW-1:0]    Q6,
   input  logic signed [DW-1:0]    Q5,
   input  logic signed [DW-1:0]    Q4,
   input  logic signed [DW-1:0]    Q3,
   input  logic signed [DW-1:0]    Q2,
   input  logic signed [DW-1:0]    Q1,
   input  logic signed [DW-1:0]    Q0,
   input  logic signed [DW-1:0]    X7,
   input  logic signed [DW-1:0]    X6,
   input  logic signed [DW-1:0]    X5,
   input  logic signed [DW-1:0]    X4,
   input  logic signed [DW-1:0]    X3,
   input  logic signed [DW-1:0]    X2,
   input  logic signed [DW-1:0]    X1,
   input  logic signed [DW-1:0]    X0,
   output logic signed [ACC_W-1:0] y,
   output logic                    y_valid
);

   localparam int PW = 2 * DW;
   localparam int SW = 2 * DW + 3;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   state_t                  state_q, state_d;
   logic [AW-1:0]           addr_q, addr_d;
   logic                    cen_q, cen_d;
   logic                    busy_q, busy_d;
   logic [READ_LAT-1:0]     rd_v_q, rd_v_d;
   logic [READ_LAT-1:0]     rd_last_q, rd_last_d;
   logic signed [PW-1:0]    prod_q [8];
   logic signed [PW-1:0]    prod_d [8];
   logic                    prod_v_q, prod_v_d;
   logic                    prod_last_q, prod_last_d;
   logic signed [SW-1:0]    sum_q, sum_d;
   logic                    sum_v_q, sum_v_d;
   logic                    sum_last_q, sum_last_d;
   logic signed [ACC_W-1:0] acc_q, acc_d;
   logic signed [ACC_W-1:0] y_q, y_d;
   logic                    y_valid_q, y_valid_d;

   logic signed [DW-1:0]    q_arr [8];
   logic signed [DW-1:0]    x_arr [8];
   logic                    issue;
   logic                    issue_last;

   assign q_arr[0] = Q0;  assign q_arr[1] = Q1;  assign q_arr[2] = Q2;  assign q_arr[3] = Q3;
   assign q_arr[4] = Q4;  assign q_arr[5] = Q5;  assign q_arr[6] = Q6;  assign q_arr[7] = Q7;
   assign x_arr[0] = X0;  assign x_arr[1] = X1;  assign x_arr[2] = X2;  assign x_arr[3] = X3;
   assign x_arr[4] = X4;  assign x_arr[5] = X5;  assign x_arr[6] = X6;  assign x_arr[7] = X7;

   // Address and CEN are registered alongside the state, so a RUN cycle is
   // exactly a cycle in which a valid address sits on the memory pins.
   assign issue      = (state_q == S_RUN);
   assign issue_last = issue && (addr_q == AW'(TAPS - 1));

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      cen_d       = cen_q;
      busy_d      = busy_q;
      y_d         = y_q;
      y_valid_d   = 1'b0;

      // Valid/last tags ride along with the read latency so only RUN taps
      // can ever reach the accumulator.
      rd_v_d       = rd_v_q << 1;
      rd_v_d[0]    = issue;
      rd_last_d    = rd_last_q << 1;
      rd_last_d[0] = issue_last;

      for (int i = 0; i < 8; i++) begin
         prod_d[i] = PW'(q_arr[i]) * PW'(x_arr[i]);
      end
      prod_v_d    = rd_v_q[READ_LAT-1];
      prod_last_d = rd_last_q[READ_LAT-1];

      sum_d = '0;
      for (int i = 0; i < 8; i++) begin
         sum_d = sum_d + SW'(prod_q[i]);
      end
      sum_v_d    = prod_v_q;
      sum_last_d = prod_last_q;

      acc_d = acc_q;
      if (sum_v_q) begin
         acc_d = acc_q + ACC_W'(sum_q);
      end

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_RUN;
               addr_d  = '0;
               cen_d   = 1'b0;
               busy_d  = 1'b1;
               acc_d   = '0;
            end
         end
         S_RUN: begin
            if (issue_last) begin
               state_d = S_DRAIN;
               cen_d   = 1'b1;
            end else begin
               addr_d = addr_q + AW'(1);
            end
         end
         S_DRAIN: begin
            // The final tap's sum is being folded in this cycle; publish the
            // completed total directly so y lands with the last accumulation.
            if (sum_v_q && sum_last_q) begin
               state_d   = S_IDLE;
               busy_d    = 1'b0;
               y_d       = acc_d;
               y_valid_d = 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
            cen_d   = 1'b1;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         addr_q      <= '0;
         cen_q       <= 1'b1;
         busy_q      <= 1'b0;
         rd_v_q      <= '0;
         rd_last_q   <= '0;
         for (int i = 0; i < 8; i++) prod_q[i] <= '0;
         prod_v_q    <= 1'b0;
         prod_last_q <= 1'b0;
         sum_q       <= '0;
         sum_v_q     <= 1'b0;
         sum_last_q  <= 1'b0;
         acc_q       <= '0;
         y_q         <= '0;
         y_valid_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         cen_q       <= cen_d;
         busy_q      <= busy_d;
         rd_v_q      <= rd_v_d;
         rd_last_q   <= rd_last_d;
         for (int i = 0; i < 8; i++) prod_q[i] <= prod_d[i];
         prod_v_q    <= prod_v_d;
         prod_last_q <= prod_last_d;
         sum_q       <= sum_d;
         sum_v_q     <= sum_v_d;
         sum_last_q  <= sum_last_d;
         acc_q       <= acc_d;
         y_q         <= y_d;
         y_valid_q   <= y_valid_d;
      end
   end

   assign A0 = addr_q;  assign A1 = addr_q;  assign A2 = addr_q;  assign A3 = addr_q;
   assign A4 = addr_q;  assign A5 = addr_q;  assign A6 = addr_q;  assign A7 = addr_q;
   assign XA      = addr_q;
   assign CEN     = cen_q;
   assign WEN     = 1'b1;
   assign busy    = busy_q;
   assign y       = y_q;
   assign y_valid = y_valid_q;

endmodule

// File: tb/tb_fir_tap_mac.sv
// tb/tb_fir_tap_mac.sv - self-checking bench for fir_tap_mac with memory and result model

module tb_fir_tap_mac;

   localparam int TAPS  = 64;
   localparam int LAT_Y = 67;   // y_valid cycle index counted from c0

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               start = 1'b0;
   logic               busy;
   logic [5:0]         a_o [8];
   logic               cen, wen;
   logic [5:0]         xa;
   logic signed [15:0] q_i [8];
   logic signed [15:0] x_i [8];
   logic signed [40:0] y;
   logic               y_valid;

   logic signed [15:0] qmem [8][64];
   logic signed [15:0] xmem [8][64];

   int     errors = 0;
   int     checks = 0;
   int     cyc = 0;
   int     mt = -1;          // model: cycles since c0, -1 when idle
   longint ey = 0;           // model: expected y
   longint pend = 0;
   int     ea = 0;           // model: expected address
   bit     chk_en = 0;
   int     cen_low_cnt = 0;
   int     yv_cnt = 0;

   always #5 clk = ~clk;

   fir_tap_mac dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy),
      .A7(a_o[7]), .A6(a_o[6]), .A5(a_o[5]), .A4(a_o[4]),
      .A3(a_o[3]), .A2(a_o[2]), .A1(a_o[1]), .A0(a_o[0]),
      .CEN(cen), .WEN(wen), .XA(xa),
      .Q7(q_i[7]), .Q6(q_i[6]), .Q5(q_i[5]), .Q4(q_i[4]),
      .Q3(q_i[3]), .Q2(q_i[2]), .Q1(q_i[1]), .Q0(q_i[0]),
      .X7(x_i[7]), .X6(x_i[6]), .X5(x_i[5]), .X4(x_i[4]),
      .X3(x_i[3]), .X2(x_i[2]), .X1(x_i[1]), .X0(x_i[0]),
      .y(y), .y_valid(y_valid)
   );

   // synchronous-read memories, one cycle latency
   always @(posedge clk) begin
      if (!cen) begin
         for (int b = 0; b < 8; b++) begin
            q_i[b] <= qmem[b][a_o[b]];
            x_i[b] <= xmem[b][xa];
         end
      end
   end

   function automatic longint model_sum();
      longint s = 0;
      for (int b = 0; b < 8; b++)
         for (int k = 0; k < TAPS; k++)
            s += longint'(qmem[b][k]) * longint'(xmem[b][k]);
      return s;
   endfunction

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: actual=%0d expected=%0d", name, cyc, act, exp);
      end
   endtask

   // behavioural timeline: result due LAT_Y cycles after c0
   always @(posedge clk) begin
      cyc++;
      if (rst) begin
         mt = -1; ey = 0; ea = 0;
      end else if ((mt < 0 || mt == LAT_Y) && start) begin
         mt = 0; pend = model_sum(); ea = 0;
      end else if (mt >= 0 && mt < LAT_Y) begin
         mt++;
         if (mt < TAPS) ea = mt;
         if (mt == LAT_Y) ey = pend;
      end else begin
         mt = -1;
      end
   end

   always @(negedge clk) begin
      if (!cen) cen_low_cnt++;
      if (y_valid) yv_cnt++;
      if (chk_en) begin
         chk("busy", longint'(busy), longint'(mt >= 0 && mt < LAT_Y));
         chk("y_valid", longint'(y_valid), longint'(mt == LAT_Y));
         chk("cen", longint'(cen), longint'(!(mt >= 0 && mt < TAPS)));
         chk("wen", longint'(wen), 64'sd1);
         chk("xa", longint'(xa), longint'(ea));
         for (int b = 0; b < 8; b++) chk("addr", longint'(a_o[b]), longint'(ea));
         chk("y", longint'(y), ey);
      end
   end

   task automatic fill(input int mode);
      for (int b = 0; b < 8; b++)
         for (int k = 0; k < TAPS; k++)
            case (mode)
               0: begin qmem[b][k] = 16'sd1;      xmem[b][k] = 16'sd1;      end
               1: begin qmem[b][k] = -16'sd1;     xmem[b][k] = 16'sd32767;  end
               2: begin qmem[b][k] = -16'sd32768; xmem[b][k] = -16'sd32768; end
               3: begin qmem[b][k] = 16'(k);      xmem[b][k] = 16'sd1;      end
               default: begin
                  qmem[b][k] = 16'($urandom);
                  xmem[b][k] = 16'($urandom);
               end
            endcase
   endtask

   task automatic wait_yv(input string name, output int lat, input int s);
      bit got = 0;
      lat = -1;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (y_valid) begin got = 1; lat = cyc - s; break; end
      end
      if (!got) chk({name, "_timeout"}, 64'sd0, 64'sd1);
   endtask

   task automatic run_one(input string name, input bit use_lit, input longint lit);
      int s, lat;
      longint exp_y;
      exp_y = model_sum();
      if (use_lit) begin
         chk({name, "_model"}, exp_y, lit);
         exp_y = lit;
      end
      cen_low_cnt = 0; yv_cnt = 0;
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0; s = cyc;
      wait_yv(name, lat, s);
      chk({name, "_latency"}, longint'(lat), longint'(LAT_Y));
      chk({name, "_y"}, longint'(y), exp_y);
      chk({name, "_busy_in_yv"}, longint'(busy), 64'sd0);
      repeat (5) @(negedge clk);
      chk({name, "_cen_low_cycles"}, longint'(cen_low_cnt), 64'sd64);
      chk({name, "_yv_pulses"}, longint'(yv_cnt), 64'sd1);
   endtask

   initial begin
      int s, lat;
      fill(0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      chk_en = 1;
      @(negedge clk);
      chk("reset_busy", longint'(busy), 64'sd0);
      chk("reset_cen", longint'(cen), 64'sd1);
      chk("reset_y", longint'(y), 64'sd0);
      chk("reset_a0", longint'(a_o[0]), 64'sd0);

      run_one("unity", 1, 64'sd512);
      fill(1); run_one("sign", 1, -64'sd16776704);
      fill(2); run_one("extreme", 1, 64'sd549755813888);
      fill(3); run_one("ramp", 1, 64'sd16128);

      // start re-asserted mid-run is ignored
      fill(0);
      cen_low_cnt = 0; yv_cnt = 0;
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0; s = cyc;
      repeat (19) @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      wait_yv("ignore", lat, s);
      chk("ignore_latency", longint'(lat), longint'(LAT_Y));
      repeat (80) @(negedge clk);
      chk("ignore_yv_pulses", longint'(yv_cnt), 64'sd1);

      // start held through y_valid: back-to-back
      fill(3);
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); s = cyc;
      wait_yv("b2b_first", lat, s);
      chk("b2b_first_y", longint'(y), 64'sd16128);
      @(posedge clk); #1 start = 1'b0; s = cyc;
      wait_yv("b2b_second", lat, s);
      chk("b2b_second_latency", longint'(lat), longint'(LAT_Y));
      chk("b2b_second_y", longint'(y), 64'sd16128);
      repeat (3) @(negedge clk);

      // reset in RUN aborts the computation
      fill(0);
      yv_cnt = 0;
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      repeat (30) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("abort_busy", longint'(busy), 64'sd0);
      chk("abort_cen", longint'(cen), 64'sd1);
      chk("abort_a0", longint'(a_o[0]), 64'sd0);
      chk("abort_y", longint'(y), 64'sd0);
      repeat (100) @(negedge clk);
      chk("abort_no_yv", longint'(yv_cnt), 64'sd0);
      run_one("after_abort", 1, 64'sd512);

      for (int r = 0; r < 4; r++) begin
         fill(4);
         repeat ($urandom_range(0, 5)) @(posedge clk);
         run_one("random", 0, 64'sd0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
